freq_meter: RTL and testbench
=============================

# freq_meter

Gated-window frequency meter for the speaker subsystem. It counts rising edges of an asynchronous input over a fixed window of `clk` cycles and reports the count once per window, so tone and beat clocks generated elsewhere can be measured and shown. The block runs back to back with no dead cycles between windows. It sits beside the frequency dividers as their measurement counterpart: the dividers turn `clk` into a slow clock, and this block turns a clock back into a number.

## Interface
- `GATE_CYCLES`, default 100_000_000: window length in `clk` cycles (1 s at 100 MHz). Legal range is 2 to 2^27.
- `CNT_W`, default 27: width of the edge counter and of `freq`.
- `clk` input, 1 bit: system clock. Everything is on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `en` input, 1 bit: measurement enable, synchronous, level-sensitive.
- `sig_in` input, 1 bit: signal under measurement, asynchronous to `clk`.
- `freq` output, `CNT_W` bits: edge count latched at the end of the last completed window.
- `valid` output, 1 bit: one-cycle pulse when `freq` and `ovf` update.
- `ovf` output, 1 bit: the last completed window saturated the counter. Latched together with `freq`.
- `busy` output, 1 bit: high while a window is in progress (state COUNT).

## Operation
- **Input synchronizer.** `sig_in` passes through a 2-FF synchronizer (`s1`, `s2`) and then one history register `s3`.
  - An edge is `s2 & ~s3`.
  - These registers run whenever the block is out of reset, independent of `en`.
- **FSM, two states.**
  - IDLE: `busy`=0; the gate counter and edge counter are held at 0. If `en`=1, go to COUNT on the next cycle.
  - COUNT: `busy`=1; the gate counter increments by one each cycle, and the edge counter adds 1 for each edge.
  - COUNT with `en`=0: abort the window and return to IDLE next cycle. No `valid`; `freq` and `ovf` keep their old values.
  - COUNT at the last cycle of a window (gate counter = `GATE_CYCLES`-1):
    - `freq` takes the edge count plus this cycle's edge, saturated.
    - `ovf` takes the saturation flag.
    - `valid` is 1 on the following cycle.
    - The gate counter, edge counter and saturation flag clear.
    - The FSM stays in COUNT, so the next window starts the very next cycle with no cycle lost.
- **Gate counter width.** `ceil(log2(GATE_CYCLES))` bits. It wraps only by the explicit clear at `GATE_CYCLES`-1, never by overflow.
- **Edge counter saturation.**
  - The counter saturates at 2^`CNT_W`-1.
  - An edge arriving at saturation sets the internal saturation flag.
  - The flag is sticky for the rest of the window.
- **Simultaneous events.**
  - An edge in the window's last cycle is counted in the closing window, not the new one.
  - Window end with `en`=0 in the same cycle: window end wins. `valid` fires, then the FSM goes to IDLE.
- **Reset mid-operation.** Asserting `rst_n` at any point returns immediately to IDLE. All registers clear and no `valid` is produced.

## Timing
- **Reset values.**
  - `freq`=0, `ovf`=0, `valid`=0, `busy`=0.
  - Synchronizer registers = 0.
  - State = IDLE.
- **Enable to busy.** `en` rising at cycle t gives `busy`=1 from t+1. The first window covers cycles t+1 … t+`GATE_CYCLES`.
- **Result latency.** `valid` is high at cycle t+`GATE_CYCLES`+1, one cycle wide. `freq` is stable from that cycle until the next `valid`.
- **Continuous operation.** With `en` held high, consecutive `valid` pulses are exactly `GATE_CYCLES` cycles apart.
- **Edge latency.** A `sig_in` transition reaches edge detection 2–3 cycles later. Edges that late in a window fall into the next window, which is accepted.
- **Input rate limit.** `sig_in` must stay high ≥1 `clk` and low ≥1 `clk`. The maximum measurable count is therefore `GATE_CYCLES`/2.

## Test plan
- **Reset.** Assert reset mid-window with `GATE_CYCLES`=1000 → `freq`=0, `ovf`=0, `valid`=0, `busy`=0 during reset. After release, no `valid` appears until a full window completes.
- **Periodic input.** `GATE_CYCLES`=1000, `sig_in` period 10 clk, `en` held high:
  - first `valid` gives `freq` = 100±1;
  - every later window gives `freq`=100 exactly, `ovf`=0;
  - `valid` pulses are 1000 cycles apart.
- **Constant input.** `sig_in` held at 1 for a full window → `freq`=0, `valid` pulses.
- **Abort.** `GATE_CYCLES`=1000, previous `freq`=100. Drop `en` at cycle 500 of a window → `busy`=0 next cycle, no `valid`, `freq` stays 100.
- **Overflow.** `CNT_W`=4, `GATE_CYCLES`=100, 20 edges in the window → `freq`=15, `ovf`=1. The next window with 5 edges → `freq`=5, `ovf`=0.
- **Boundary edge.** Place an edge so that detection lands on window cycle `GATE_CYCLES`-1 → it is counted in the closing window. The new window starts at 0 with no cycle lost, so `valid` spacing stays exactly `GATE_CYCLES`.

Source files
------------

// File: rtl/freq_meter.sv
// Gated-window frequency meter: counts synchronized rising edges of sig_in over
// GATE_CYCLES clk cycles and publishes the count once per back-to-back window.
module freq_meter #(
   parameter int unsigned GATE_CYCLES = 100_000_000,
   parameter int unsigned CNT_W       = 27
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             sig_in,
   output logic [CNT_W-1:0] freq,
   output logic             valid,
   output logic             ovf,
   output logic             busy
);

   localparam int unsigned     GW        = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   typedef enum logic {StIdle, StCount} state_e;

   state_e           state_q, state_d;
   logic             s1_q, s2_q, s3_q;
   logic             edge_det;
   logic [GW-1:0]    gate_q, gate_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] freq_q, freq_d;
   logic             sat_q, sat_d;
   logic             ovf_q, ovf_d;
   logic             valid_q, valid_d;
   logic             last;
   logic             at_max;
   logic [CNT_W-1:0] cnt_inc;
   logic             sat_inc;

   // Synchronizer and edge history run regardless of en.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= sig_in;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         gate_q  <= '0;
         cnt_q   <= '0;
         sat_q   <= 1'b0;
         freq_q  <= '0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         gate_q  <= gate_d;
         cnt_q   <= cnt_d;
         sat_q   <= sat_d;
         freq_q  <= freq_d;
         ovf_q   <= ovf_d;
         valid_q <= valid_d;
      end
   end

   always_comb begin
      edge_det = s2_q & ~s3_q;
      at_max   = (cnt_q == CNT_MAX);
      cnt_inc  = (edge_det && !at_max) ? cnt_q + 1'b1 : cnt_q;
      sat_inc  = sat_q | (edge_det & at_max);
      last     = (gate_q == GATE_LAST);

      state_d = state_q;
      gate_d  = gate_q;
      cnt_d   = cnt_q;
      sat_d   = sat_q;
      freq_d  = freq_q;
      ovf_d   = ovf_q;
      valid_d = 1'b0;

      case (state_q)
         StIdle: begin
            gate_d = '0;
            cnt_d  = '0;
            sat_d  = 1'b0;
            if (en) state_d = StCount;
         end
         StCount: begin
            if (last) begin
               // Window end takes priority over en dropping in the same cycle.
               freq_d  = cnt_inc;
               ovf_d   = sat_inc;
               valid_d = 1'b1;
               gate_d  = '0;
               cnt_d   = '0;
               sat_d   = 1'b0;
               if (!en) state_d = StIdle;
            end else if (!en) begin
               state_d = StIdle;
               gate_d  = '0;
               cnt_d   = '0;
               sat_d   = 1'b0;
            end else begin
               gate_d = gate_q + 1'b1;
               cnt_d  = cnt_inc;
               sat_d  = sat_inc;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign freq  = freq_q;
   assign ovf   = ovf_q;
   assign valid = valid_q;
   assign busy  = (state_q == StCount);

endmodule

// File: tb/tb_freq_meter.sv
// Scoreboard bench: instance a (1000-cycle window) and instance b (4-bit counter,
// 100-cycle window); stimulus pushes expected results, monitors pop on valid.
`timescale 1ns/1ps
module tb_freq_meter;

   localparam int unsigned GA = 1000;
   localparam int unsigned GB = 100;

   typedef struct {
      int freq;
      int ovf;
      int tol;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_a = 1'b0, en_a = 1'b0, sig_a = 1'b0;
   logic        rst_b = 1'b0, en_b = 1'b0, sig_b = 1'b0;
   logic [26:0] freq_a;
   logic [3:0]  freq_b;
   logic        valid_a, ovf_a, busy_a;
   logic        valid_b, ovf_b, busy_b;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   last_a = -1;
   int   last_b = -1;
   int   mode_a = 0;
   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;

   freq_meter #(.GATE_CYCLES(GA), .CNT_W(27)) u_a (
      .clk(clk), .rst_n(rst_a), .en(en_a), .sig_in(sig_a),
      .freq(freq_a), .valid(valid_a), .ovf(ovf_a), .busy(busy_a)
   );

   freq_meter #(.GATE_CYCLES(GB), .CNT_W(4)) u_b (
      .clk(clk), .rst_n(rst_b), .en(en_b), .sig_in(sig_b),
      .freq(freq_b), .valid(valid_b), .ovf(ovf_b), .busy(busy_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int req, input int tol);
      n_cmp++;
      if (act < req - tol || act > req + tol) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (tol %0d) at cycle %0d", name, act, req, tol,
                  cyc);
      end
   endtask

   function automatic exp_t mk(input int f, input int o, input int t);
      exp_t e;
      e.freq = f;
      e.ovf  = o;
      e.tol  = t;
      return e;
   endfunction

   // Period-10 square wave (mode 0) or held high (mode 1), driven off the clock.
   initial begin
      int ph = 0;
      forever begin
         @(posedge clk);
         #1;
         if (mode_a == 0) begin
            ph    = (ph + 1) % 10;
            sig_a = (ph < 5);
         end else begin
            sig_a = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (valid_a) begin
         if (qa.size() == 0) begin
            chk("unexpected_valid_a", 1, 0, 0);
         end else begin
            ea = qa.pop_front();
            chk("freq_a", int'(freq_a), ea.freq, ea.tol);
            chk("ovf_a", int'(ovf_a), ea.ovf, 0);
         end
         if (last_a >= 0) chk("spacing_a", cyc - last_a, GA, 0);
         last_a = cyc;
      end
      if (!rst_a || !busy_a) last_a = -1;
   end

   always @(negedge clk) begin
      if (valid_b) begin
         if (qb.size() == 0) begin
            chk("unexpected_valid_b", 1, 0, 0);
         end else begin
            eb = qb.pop_front();
            chk("freq_b", int'(freq_b), eb.freq, eb.tol);
            chk("ovf_b", int'(ovf_b), eb.ovf, 0);
         end
         if (last_b >= 0) chk("spacing_b", cyc - last_b, GB, 0);
         last_b = cyc;
      end
      if (!rst_b || !busy_b) last_b = -1;
   end

   task automatic drain_a(input int budget);
      for (int i = 0; i < budget && qa.size() != 0; i++) @(posedge clk);
      #1;
      chk("pending_a", qa.size(), 0, 0);
   endtask

   // Sig_b rises after posedge p; edges land 2 cycles later.
   function automatic logic sig_b_at(input int p);
      return (p >= 10 && p < 90 && (p - 10) % 4 < 2) ||
             (p >= 110 && p < 130 && (p - 110) % 4 < 2) ||
             (p >= 298 && p < 350) || (p >= 399);
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_freq_b", int'(freq_b), 0, 0);
      chk("rst_ovf_b", int'(ovf_b), 0, 0);
      chk("rst_valid_b", int'(valid_b), 0, 0);
      chk("rst_busy_b", int'(busy_b), 0, 0);

      // Reset asserted in the middle of a window.
      rst_a = 1'b1;
      en_a  = 1'b1;
      repeat (500) @(posedge clk);
      #1;
      chk("pre_rst_busy_a", int'(busy_a), 1, 0);
      rst_a = 1'b0;
      #1;
      chk("rst_freq_a", int'(freq_a), 0, 0);
      chk("rst_ovf_a", int'(ovf_a), 0, 0);
      chk("rst_valid_a", int'(valid_a), 0, 0);
      chk("rst_busy_a", int'(busy_a), 0, 0);
      repeat (5) @(posedge clk);
      #1;
      rst_a = 1'b1;

      // Periodic input: first window may be off by one, later ones exact.
      qa.push_back(mk(100, 0, 1));
      qa.push_back(mk(100, 0, 0));
      qa.push_back(mk(100, 0, 0));
      drain_a(3 * GA + 20);

      // Abort half way through a window.
      repeat (499) @(posedge clk);
      #1;
      chk("abort_busy_before", int'(busy_a), 1, 0);
      en_a = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_busy_after", int'(busy_a), 0, 0);
      repeat (1200) @(posedge clk);
      #1;
      chk("abort_freq_kept", int'(freq_a), 100, 0);
      chk("abort_ovf_kept", int'(ovf_a), 0, 0);

      // Constant high input gives zero edges.
      mode_a = 1;
      repeat (10) @(posedge clk);
      #1;
      qa.push_back(mk(0, 0, 0));
      en_a = 1'b1;
      drain_a(GA + 20);
      en_a = 1'b0;

      // Instance b: saturation, recovery, boundary edges, window end with en low.
      rst_b = 1'b1;
      repeat (3) @(posedge clk);
      qb.push_back(mk(15, 1, 0));
      qb.push_back(mk(5, 0, 0));
      qb.push_back(mk(1, 0, 0));
      qb.push_back(mk(0, 0, 0));
      qb.push_back(mk(1, 0, 0));
      @(posedge clk);
      #1;
      en_b = 1'b1;
      for (int p = 1; p <= 505; p++) begin
         @(posedge clk);
         #1;
         sig_b = sig_b_at(p);
         if (p == 500) en_b = 1'b0;
      end
      chk("end_busy_b", int'(busy_b), 0, 0);
      chk("pending_b", qb.size(), 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
